seq_det_arb: RTL and testbench
==============================

SEQ_DET_ARB -- requirements
Module: seq_det_arb

Interface
REQ-001 SHALL have parameter PATTERN, 8'h07, match pattern, LSB = most recent bit.
REQ-002 SHALL have parameter PAT_LEN, 3, pattern length in bits, legal 1..8.
REQ-003 SHALL have parameter FRAME_LEN, 8, bits per frame, legal 1..511.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port req, input, 4, per-requester frame request, held high for the whole frame.
REQ-007 SHALL have port din, input, 4, per-requester serial data bit.
REQ-008 SHALL have port gnt, output, 4, one-hot grant.
REQ-009 SHALL have port busy, output, 1, high in GRANT, RUN and DONE.
REQ-010 SHALL have port det, output, 1, one-cycle match pulse.
REQ-011 SHALL have port done, output, 1, one-cycle end-of-frame pulse.
REQ-012 SHALL have port done_id, output, 2, index of the requester that owned the finished frame.
REQ-013 SHALL have port aborted, output, 1, qualifies done: frame ended early.
REQ-014 SHALL have port match_cnt, output, 8, frame match count, valid while done=1.

Function
REQ-015 SHALL implement FSM IDLE -> GRANT -> RUN -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with any req bit high, select the winner by round-robin starting at rr_ptr and enter GRANT on the next edge; with req=0 it SHALL stay in IDLE.
REQ-017 SHALL, in GRANT (one cycle), assert gnt[winner] and clear the shift register, bit counter, frame counter and match count.
REQ-018 SHALL hold gnt[winner] through GRANT and RUN, and drive gnt=0 in IDLE and DONE.
REQ-019 SHALL, in RUN, sample din[winner] on each edge into the shift register, for exactly FRAME_LEN cycles, then enter DONE.
REQ-020 SHALL flag a match when at least PAT_LEN bits have been collected since the last clear and the low PAT_LEN shift bits equal PATTERN[PAT_LEN-1:0].
REQ-021 SHALL pulse det for one cycle, on the cycle after the edge that sampled the matching bit.
REQ-022 SHALL increment match_cnt on each match and saturate it at 255.
REQ-023 SHALL, if req[winner] falls during RUN, stop sampling on that edge, enter DONE and set aborted=1; matches already counted are kept.
REQ-024 SHALL, in DONE (one cycle), assert done with done_id=winner and set rr_ptr=winner+1 mod 4.
REQ-025 SHALL ignore changes on req bits other than the winner's while busy=1.
REQ-026 SHALL hold det, aborted and match_cnt at 0 except in the cycles defined above.

Reset
REQ-027 SHALL, on rst low, immediately force state=IDLE, rr_ptr=0, gnt=0, busy=0, det=0, done=0, done_id=0, aborted=0, match_cnt=0, and clear all counters and the shift register, including mid-frame.
REQ-028 SHALL re-evaluate req on the first edge after rst rises.

Configuration
REQ-029 SHALL support the macro SEQ_DET_OVERLAP_EN: when defined, the collected-bit count SHALL NOT clear on a match, so overlapping matches are detected.
REQ-030 SHALL, without SEQ_DET_OVERLAP_EN, clear the collected-bit count to 0 on each match, giving non-overlapping detection.

Verification
REQ-031 Bench SHALL check non-overlap case: defaults, req=4'b0001, din[0]=1,1,1,1,1,0,1,1 -> det once after bit 3, done_id=0, match_cnt=1, aborted=0.
REQ-032 Bench SHALL check overlap case: same stimulus with SEQ_DET_OVERLAP_EN -> det after bits 3, 4 and 5, match_cnt=3.
REQ-033 Bench SHALL check round-robin order: req=4'b1111 held -> successive grants 0001, 0010, 0100, 1000, 0001.
REQ-034 Bench SHALL check abort: req[0] dropped on RUN cycle 4 with din=1,1,1,1 -> DONE next, aborted=1, match_cnt=1.
REQ-035 Bench SHALL check async reset: rst low mid-RUN, asynchronous to clk -> all outputs 0 without waiting for a clk edge; with req=4'b0110 after release, the next grant is 0010.
REQ-036 Bench SHALL check saturation: PAT_LEN=1, PATTERN=8'h01, FRAME_LEN=300, din all ones -> match_cnt=255.

Source files
------------

// File: rtl/seq_det_arb.sv
// seq_det_arb: four-requester round-robin arbiter that grants one requester a
// frame of FRAME_LEN serial bits and counts occurrences of PATTERN in it.
// The low PAT_LEN bits of PATTERN are matched; bit 0 is the most recent bit.
// Optional feature macro: SEQ_DET_OVERLAP_EN keeps the collected-bit count on
// a match so overlapping occurrences are also detected. The default build
// restarts collection after each match, so matches never overlap.
`default_nettype none

module seq_det_arb #(
  parameter logic [7:0] PATTERN   = 8'h07,
  parameter int         PAT_LEN   = 3,
  parameter int         FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       det,
  output logic       done,
  output logic [1:0] done_id,
  output logic       aborted,
  output logic [7:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Pattern comparison only looks at the low PAT_LEN bits of the shift register.
  localparam logic [8:0] MASK_WIDE  = (9'd1 << PAT_LEN) - 9'd1;
  localparam logic [7:0] PAT_MASK   = MASK_WIDE[7:0];
  localparam logic [7:0] PAT_REF    = PATTERN & PAT_MASK;
  localparam logic [3:0] PAT_LEN_W  = 4'(PAT_LEN);
  localparam logic [8:0] FRAME_LAST = 9'(FRAME_LEN - 1);

  state_e     state_q;
  logic [1:0] rr_ptr_q;
  logic [1:0] winner_q;
  logic [7:0] shift_q;
  logic [3:0] bit_cnt_q;
  logic [8:0] frame_cnt_q;
  logic [7:0] cnt_q;
  logic [3:0] gnt_q;
  logic       busy_q;
  logic       det_q;
  logic       done_q;
  logic [1:0] done_id_q;
  logic       aborted_q;
  logic [7:0] match_out_q;

  logic [1:0] winner_d;
  logic [1:0] idx;
  logic [7:0] shift_d;
  logic [3:0] bit_cnt_inc;
  logic [3:0] bit_cnt_d;
  logic [7:0] cnt_d;
  logic       hit;

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to rr_ptr_q (offset 0) is the last assignment and wins.
  always_comb begin
    winner_d = rr_ptr_q;
    idx      = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr_q + 2'(i);
      if (req[idx]) begin
        winner_d = idx;
      end
    end
  end

  // Next values for one RUN sample: shift in the winner's bit, saturate the
  // collected-bit count at PAT_LEN, and decide whether this bit completes a match.
  always_comb begin
    shift_d     = (shift_q << 1) | {7'd0, din[winner_q]};
    bit_cnt_inc = (bit_cnt_q >= PAT_LEN_W) ? bit_cnt_q : bit_cnt_q + 4'd1;
    hit         = (bit_cnt_inc >= PAT_LEN_W) && ((shift_d & PAT_MASK) == PAT_REF);
`ifdef SEQ_DET_OVERLAP_EN
    bit_cnt_d   = bit_cnt_inc;
`else
    bit_cnt_d   = hit ? 4'd0 : bit_cnt_inc;
`endif
    cnt_d       = (hit && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  end

  // Arbiter/detector FSM with all outputs registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      det_q       <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      aborted_q   <= 1'b0;
      match_out_q <= '0;
    end else begin
      det_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            winner_q <= winner_d;
            gnt_q    <= 4'b0001 << winner_d;
            busy_q   <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          shift_q     <= '0;
          bit_cnt_q   <= '0;
          frame_cnt_q <= '0;
          cnt_q       <= '0;
          state_q     <= RUN;
        end
        RUN: begin
          if (!req[winner_q]) begin
            gnt_q       <= '0;
            done_q      <= 1'b1;
            done_id_q   <= winner_q;
            aborted_q   <= 1'b1;
            match_out_q <= cnt_q;
            state_q     <= DONE;
          end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            det_q       <= hit;
            frame_cnt_q <= frame_cnt_q + 9'd1;
            if (frame_cnt_q == FRAME_LAST) begin
              gnt_q       <= '0;
              done_q      <= 1'b1;
              done_id_q   <= winner_q;
              match_out_q <= cnt_d;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          done_id_q   <= '0;
          aborted_q   <= 1'b0;
          match_out_q <= '0;
          busy_q      <= 1'b0;
          rr_ptr_q    <= winner_q + 2'd1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign det       = det_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign aborted   = aborted_q;
  assign match_cnt = match_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_arb.sv
// tb_seq_det_arb: directed frames with hand-computed results pushed into a
// scoreboard; negedge monitors pop and compare whenever a DUT raises done.
// A second instance (PAT_LEN=1, FRAME_LEN=300) exercises match-count saturation.
module tb_seq_det_arb;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        ab;
    logic [7:0]  cnt;
    logic [15:0] mask;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       busy;
  logic       det;
  logic       done;
  logic [1:0] done_id;
  logic       aborted;
  logic [7:0] match_cnt;

  logic [3:0] reqS;
  logic [3:0] dinS;
  logic [3:0] gntS;
  logic       busyS;
  logic       detS;
  logic       doneS;
  logic [1:0] doneIdS;
  logic       abortedS;
  logic [7:0] matchCntS;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];
  exp_t expQS[$];

  logic        prevBusy  = 1'b0;
  int          cyc       = 0;
  int          detStray  = 0;
  logic [3:0]  gntSeen   = '0;
  logic [15:0] detMask   = '0;

  seq_det_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .busy      (busy),
    .det       (det),
    .done      (done),
    .done_id   (done_id),
    .aborted   (aborted),
    .match_cnt (match_cnt)
  );

  seq_det_arb #(
    .PATTERN   (8'h01),
    .PAT_LEN   (1),
    .FRAME_LEN (300)
  ) dutSat (
    .clk       (clk),
    .rst       (rst),
    .req       (reqS),
    .din       (dinS),
    .gnt       (gntS),
    .busy      (busyS),
    .det       (detS),
    .done      (doneS),
    .done_id   (doneIdS),
    .aborted   (abortedS),
    .match_cnt (matchCntS)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mkExp(input logic [3:0] g, input logic [1:0] id, input logic ab,
                                 input logic [7:0] cnt, input logic [15:0] mask);
    exp_t e;
    e.gnt  = g;
    e.id   = id;
    e.ab   = ab;
    e.cnt  = cnt;
    e.mask = mask;
    return e;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Pops the oldest expectation for the main instance and compares a finished frame.
  task automatic checkOutput(input logic [3:0] g, input logic [1:0] id, input logic ab,
                             input logic [7:0] cnt, input logic [15:0] mask);
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected done: id=%0d with no pending expectation", id);
    end else begin
      e = expQ.pop_front();
      compare("grant", {28'd0, g}, {28'd0, e.gnt});
      compare("done_id", {30'd0, id}, {30'd0, e.id});
      compare("aborted", {31'd0, ab}, {31'd0, e.ab});
      compare("match_cnt", {24'd0, cnt}, {24'd0, e.cnt});
      compare("det positions", {16'd0, mask}, {16'd0, e.mask});
      compare("det outside frame", detStray, 0);
    end
  endtask

  // Main-instance monitor: tracks frame cycle index from the GRANT cycle so det
  // pulses map to bit positions (bit k shows det in cycle k+1), checks on done.
  always @(negedge clk) begin
    if (!rst) begin
      prevBusy = 1'b0;
    end else begin
      if (busy && !prevBusy) begin
        cyc     = 0;
        gntSeen = gnt;
        detMask = '0;
      end else if (busy) begin
        cyc++;
      end
      if (det) begin
        if (busy && cyc >= 2 && cyc < 18) detMask = detMask | (16'd1 << (cyc - 2));
        else detStray++;
      end
      if (done) checkOutput(gntSeen, done_id, aborted, match_cnt, detMask);
      prevBusy = busy;
    end
  end

  // Saturation-instance monitor: compares owner, abort flag and count on done.
  always @(negedge clk) begin
    exp_t e;
    if (rst && doneS) begin
      if (expQS.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected sat done: count=%0d with no pending expectation", matchCntS);
      end else begin
        e = expQS.pop_front();
        compare("sat done_id", {30'd0, doneIdS}, {30'd0, e.id});
        compare("sat aborted", {31'd0, abortedS}, {31'd0, e.ab});
        compare("sat match_cnt", {24'd0, matchCntS}, {24'd0, e.cnt});
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("[TB] FAIL idle timeout: busy=%0b, expected 0", busy);
    end
  endtask

  task automatic waitDone(input bit sat, input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if ((sat && doneS) || (!sat && done)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL done timeout: no done within %0d cycles (sat=%0b)", bound, sat);
    end
  endtask

  // Drives one frame: req set in IDLE, bit k (bits[k-1]) presented during RUN cycle k.
  // abortAt>0 drops req instead of presenting that bit.
  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] bits, input int nBits,
                               input int abortAt, input exp_t e);
    expQ.push_back(e);
    waitIdle();
    @(posedge clk); #2;
    req = r;
    din = '0;
    @(posedge clk);
    @(posedge clk); #2;
    for (int k = 0; k < nBits; k++) begin
      if (abortAt == k + 1) begin
        req = '0;
        @(posedge clk); #2;
        break;
      end
      din = {4{bits[k]}};
      @(posedge clk); #2;
    end
    req = '0;
    din = '0;
  endtask

  initial begin
    req  = '0;
    din  = '0;
    reqS = '0;
    dinS = '0;
    rst  = 1'b1;
    #1 rst = 1'b0;
    #2;
    $display("[TB] reset state");
    compare("reset gnt", {28'd0, gnt}, 32'd0);
    compare("reset busy", {31'd0, busy}, 32'd0);
    compare("reset det", {31'd0, det}, 32'd0);
    compare("reset done", {31'd0, done}, 32'd0);
    compare("reset done_id", {30'd0, done_id}, 32'd0);
    compare("reset aborted", {31'd0, aborted}, 32'd0);
    compare("reset match_cnt", {24'd0, match_cnt}, 32'd0);
    #9 rst = 1'b1;

    $display("[TB] pattern frame 1,1,1,1,1,0,1,1");
`ifdef SEQ_DET_OVERLAP_EN
    applyStimulus(4'b0001, 16'h00DF, 8, 0, mkExp(4'b0001, 2'd0, 1'b0, 8'd3, 16'h001C));
`else
    applyStimulus(4'b0001, 16'h00DF, 8, 0, mkExp(4'b0001, 2'd0, 1'b0, 8'd1, 16'h0004));
`endif

    $display("[TB] abort on RUN cycle 4");
    applyStimulus(4'b0001, 16'h000F, 8, 4, mkExp(4'b0001, 2'd0, 1'b1, 8'd1, 16'h0004));

    $display("[TB] asynchronous reset mid-frame");
    waitIdle();
    @(posedge clk); #2;
    req = 4'b0001;
    din = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #3;
    compare("busy before reset", {31'd0, busy}, 32'd1);
    compare("gnt before reset", {28'd0, gnt}, 32'd1);
    rst = 1'b0;
    #1;
    compare("async gnt", {28'd0, gnt}, 32'd0);
    compare("async busy", {31'd0, busy}, 32'd0);
    compare("async det", {31'd0, det}, 32'd0);
    compare("async done", {31'd0, done}, 32'd0);
    compare("async done_id", {30'd0, done_id}, 32'd0);
    compare("async aborted", {31'd0, aborted}, 32'd0);
    compare("async match_cnt", {24'd0, match_cnt}, 32'd0);
    req = 4'b0110;
    din = '0;
    expQ.push_back(mkExp(4'b0010, 2'd1, 1'b0, 8'd0, 16'h0000));
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    waitDone(1'b0, 40);
    req = '0;

    $display("[TB] round-robin with all requests held");
    @(posedge clk); #3;
    rst = 1'b0;
    req = 4'hF;
    din = '0;
    expQ.push_back(mkExp(4'b0001, 2'd0, 1'b0, 8'd0, 16'h0000));
    expQ.push_back(mkExp(4'b0010, 2'd1, 1'b0, 8'd0, 16'h0000));
    expQ.push_back(mkExp(4'b0100, 2'd2, 1'b0, 8'd0, 16'h0000));
    expQ.push_back(mkExp(4'b1000, 2'd3, 1'b0, 8'd0, 16'h0000));
    expQ.push_back(mkExp(4'b0001, 2'd0, 1'b0, 8'd0, 16'h0000));
    @(posedge clk); #3;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) waitDone(1'b0, 40);
    req = '0;

    $display("[TB] match count saturation over 300 ones");
    expQS.push_back(mkExp(4'b0001, 2'd0, 1'b0, 8'd255, 16'h0000));
    @(posedge clk); #2;
    reqS = 4'b0001;
    dinS = 4'hF;
    waitDone(1'b1, 400);
    reqS = '0;
    dinS = '0;

    repeat (5) @(negedge clk);
    compare("pending expectations", expQ.size(), 0);
    compare("pending sat expectations", expQS.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
